// File: rtl/nubus_mem_initiator.sv
`default_nettype none
// ============================================================================
// nubus_mem_initiator -- command FIFO feeding a single-outstanding initiator
// on the card-internal mem_valid/mem_ready bus; one in-order response per
// command. Define NUBUS_INITIATOR_TIMEOUT_EN to build the watchdog abort path.
// Revision: 1.0
// ============================================================================
module nubus_mem_initiator #(
  parameter int FIFO_W  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_write,
  output logic        rsp_error,
  output logic        busy,
  output logic        mem_valid,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int              c_depth = 1 << FIFO_W;
  localparam logic [FIFO_W:0] c_full  = (FIFO_W + 1)'(c_depth);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
    $error("nubus_mem_initiator: TIMEOUT must lie in 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [31:0]       fifo_addr_q  [c_depth];
  logic [31:0]       fifo_wdata_q [c_depth];
  logic [3:0]        fifo_wstrb_q [c_depth];
  logic [FIFO_W-1:0] wr_ptr_q;
  logic [FIFO_W-1:0] rd_ptr_q;
  logic [FIFO_W:0]   count_q;
  logic              w_push;
  logic              w_pop;

  assign cmd_ready = (count_q != c_full);
  assign w_push    = cmd_valid & cmd_ready;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge mem_clk) begin
    if (w_push) begin
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
      fifo_wstrb_q[wr_ptr_q] <= cmd_wstrb;
    end
  end

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_write_q, rsp_write_d;
`ifdef NUBUS_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] c_wd_last = 16'(TIMEOUT - 1);
  logic        rsp_error_q, rsp_error_d;
  logic [15:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;
    w_pop       = 1'b0;
`ifdef NUBUS_INITIATOR_TIMEOUT_EN
    rsp_error_d = rsp_error_q;
    wd_d        = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          w_pop       = 1'b1;
          mem_valid_d = 1'b1;
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          mem_wdata_d = fifo_wdata_q[rd_ptr_q];
          mem_wstrb_d = fifo_wstrb_q[rd_ptr_q];
`ifdef NUBUS_INITIATOR_TIMEOUT_EN
          wd_d        = 16'd0;
`endif
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An acknowledge in the watchdog's final cycle still completes normally.
        if (mem_ready) begin
          rsp_rdata_d = (mem_wstrb_q == 4'h0) ? mem_rdata : 32'h0;
          rsp_write_d = (mem_wstrb_q != 4'h0);
          mem_valid_d = 1'b0;
`ifdef NUBUS_INITIATOR_TIMEOUT_EN
          rsp_error_d = 1'b0;
`endif
          state_d     = ST_RESP;
        end
`ifdef NUBUS_INITIATOR_TIMEOUT_EN
        else if (wd_q == c_wd_last) begin
          rsp_rdata_d = 32'h0;
          rsp_write_d = (mem_wstrb_q != 4'h0);
          rsp_error_d = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = ST_RESP;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_write_q <= 1'b0;
`ifdef NUBUS_INITIATOR_TIMEOUT_EN
      rsp_error_q <= 1'b0;
      wd_q        <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
`ifdef NUBUS_INITIATOR_TIMEOUT_EN
      rsp_error_q <= rsp_error_d;
      wd_q        <= wd_d;
`endif
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_write = rsp_write_q;
`ifdef NUBUS_INITIATOR_TIMEOUT_EN
  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif
  // The response pulse trails the RESP state by one cycle, so it keeps busy high.
  assign busy = (count_q != '0) | (state_q != ST_IDLE) | rsp_valid_q;

endmodule
`default_nettype wire
